// File: rtl/led_fade_pwm.sv
// PWM LED driver with linear cross-fade.
// Takes a 4-bit on/off pattern and ramps each channel's PWM duty toward full or zero. The duty
// changes by one step every FADE_DIV PWM frames, or snaps to the target at frame end when fading
// is disabled.
module led_fade_pwm #(
  parameter int unsigned PWM_PERIOD = 1000,
  parameter int unsigned FADE_DIV   = 10,
  parameter int unsigned CNT_W      = $clog2(PWM_PERIOD + 1)
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] led_in,
  input  logic       fade_en,
  output logic [3:0] led_out,
  output logic       fade_busy
);

  localparam int unsigned FADE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

  localparam logic [CNT_W-1:0]  PWM_MAX   = CNT_W'(PWM_PERIOD - 1);
  localparam logic [CNT_W-1:0]  DUTY_FULL = CNT_W'(PWM_PERIOD);
  localparam logic [FADE_W-1:0] FADE_MAX  = FADE_W'(FADE_DIV - 1);

  logic [CNT_W-1:0]       pwm_cnt_q, pwm_cnt_d;
  logic [FADE_W-1:0]      fade_cnt_q, fade_cnt_d;
  logic [3:0]             led_in_q;
  logic [3:0][CNT_W-1:0]  duty_q, duty_d;
  logic [3:0][CNT_W-1:0]  target;
  logic [3:0]             led_out_d;
  logic                   fade_busy_d;
  logic                   frame_end;
  logic                   step;

  // Frame counter and fade prescaler; all channels share them so they step together.
  always_comb begin
    frame_end  = (pwm_cnt_q == PWM_MAX);
    step       = frame_end && (fade_cnt_q == FADE_MAX);
    pwm_cnt_d  = frame_end ? '0 : pwm_cnt_q + CNT_W'(1);
    fade_cnt_d = fade_cnt_q;
    if (frame_end) begin
      fade_cnt_d = (fade_cnt_q == FADE_MAX) ? '0 : fade_cnt_q + FADE_W'(1);
    end
  end

  // Per-channel duty update; duty only moves on frame boundaries so no runt pulses appear.
  always_comb begin
    fade_busy_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      target[i]    = led_in_q[i] ? DUTY_FULL : '0;
      duty_d[i]    = duty_q[i];
      led_out_d[i] = (pwm_cnt_q < duty_q[i]);
      if (duty_q[i] != target[i]) begin
        fade_busy_d = 1'b1;
      end
      if (fade_en) begin
        if (step) begin
          if (duty_q[i] < target[i]) begin
            duty_d[i] = duty_q[i] + CNT_W'(1);
          end else if (duty_q[i] > target[i]) begin
            duty_d[i] = duty_q[i] - CNT_W'(1);
          end
        end
      end else if (frame_end) begin
        duty_d[i] = target[i];
      end
    end
  end

  // State registers; reset clears duty and drives outputs low immediately.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pwm_cnt_q  <= '0;
      fade_cnt_q <= '0;
      led_in_q   <= '0;
      duty_q     <= '0;
      led_out    <= '0;
      fade_busy  <= 1'b0;
    end else begin
      pwm_cnt_q  <= pwm_cnt_d;
      fade_cnt_q <= fade_cnt_d;
      led_in_q   <= led_in;
      duty_q     <= duty_d;
      led_out    <= led_out_d;
      fade_busy  <= fade_busy_d;
    end
  end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Testbench for led_fade_pwm with an 8-clock frame and a 2-frame fade divider.
// A cycle-count based reference model predicts led_out and fade_busy after every clock.
// Directed phases then check per-frame high-time against the expected ramp shapes.
module tb_led_fade_pwm;

  localparam int unsigned PER = 8;
  localparam int unsigned DIV = 2;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [3:0] led_in    = 4'h0;
  logic       fade_en   = 1'b1;
  logic [3:0] led_out;
  logic       fade_busy;

  led_fade_pwm #(
    .PWM_PERIOD(PER),
    .FADE_DIV  (DIV)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .led_in   (led_in),
    .fade_en  (fade_en),
    .led_out  (led_out),
    .fade_busy(fade_busy)
  );

  always #5 sys_clk = ~sys_clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int unsigned n_edge   = 0;
  int          m_duty[4];
  logic [3:0]  m_q      = 4'h0;
  logic [3:0]  m_out    = 4'h0;
  logic        m_busy   = 1'b0;
  int          hi[4];
  int          prev;
  logic        found;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    n_edge = 0;
    for (int i = 0; i < 4; i++) m_duty[i] = 0;
    m_q    = 4'h0;
    m_out  = 4'h0;
    m_busy = 1'b0;
  endtask

  // One clock: predict from pre-edge state (clock count gives frame position and fade phase),
  // commit at the edge, then compare at the following falling edge.
  task automatic tick();
    int         p;
    bit         fe;
    bit         st;
    int         tgt;
    int         nd[4];
    logic [3:0] no;
    logic       nb;
    p  = int'(n_edge % PER);
    fe = (p == int'(PER) - 1);
    st = fe && ((n_edge / PER) % DIV == DIV - 1);
    no = 4'h0;
    nb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tgt   = m_q[i] ? int'(PER) : 0;
      no[i] = (p < m_duty[i]);
      if (m_duty[i] != tgt) nb = 1'b1;
      nd[i] = m_duty[i];
      if (fade_en) begin
        if (st && m_duty[i] < tgt) nd[i] = m_duty[i] + 1;
        else if (st && m_duty[i] > tgt) nd[i] = m_duty[i] - 1;
      end else if (fe) begin
        nd[i] = tgt;
      end
    end
    @(posedge sys_clk);
    for (int i = 0; i < 4; i++) m_duty[i] = nd[i];
    m_q    = led_in;
    m_out  = no;
    m_busy = nb;
    n_edge++;
    @(negedge sys_clk);
    chk("led_out", 32'(led_out), 32'(m_out));
    chk("fade_busy", 32'(fade_busy), 32'(m_busy));
    for (int i = 0; i < 4; i++) hi[i] += int'(led_out[i]);
  endtask

  task automatic run_frame();
    for (int i = 0; i < 4; i++) hi[i] = 0;
    repeat (PER) tick();
  endtask

  task automatic align();
    while (n_edge % PER != 0) tick();
  endtask

  initial begin
    model_reset();
    // Reset held with all channels requested on.
    led_in = 4'hF;
    repeat (3) @(negedge sys_clk);
    chk("rst_led_out", 32'(led_out), 32'd0);
    chk("rst_busy", 32'(fade_busy), 32'd0);

    // Ramp channel 0 from reset: frame f shows f/2 high clocks, saturating at 8.
    led_in    = 4'b0001;
    fade_en   = 1'b1;
    sys_rst_n = 1'b1;
    for (int f = 0; f < 18; f++) begin
      run_frame();
      chk("ramp_hi0", 32'(hi[0]), 32'((f / 2 > 8) ? 8 : f / 2));
    end
    chk("ramp_busy_done", 32'(fade_busy), 32'd0);

    // Cross-fade channel 0 -> channel 1; total high time stays at one full frame.
    led_in = 4'b0010;
    for (int f = 0; f < 20; f++) begin
      run_frame();
      chk("xfade_sum", 32'(hi[0] + hi[1]), 32'd8);
    end
    chk("xfade_hi0", 32'(hi[0]), 32'd0);
    chk("xfade_hi1", 32'(hi[1]), 32'd8);
    chk("xfade_busy", 32'(fade_busy), 32'd0);

    // Snap mode: all off at next frame end, then channel 3 on requested mid-frame.
    fade_en = 1'b0;
    led_in  = 4'b0000;
    run_frame();
    run_frame();
    chk("snap_off_hi1", 32'(hi[1]), 32'd0);
    repeat (3) tick();
    led_in = 4'b1000;
    hi[3]  = 0;
    align();
    chk("snap_no_partial", 32'(hi[3]), 32'd0);
    run_frame();
    chk("snap_full_hi3", 32'(hi[3]), 32'd8);
    chk("snap_busy", 32'(fade_busy), 32'd0);

    // Reversal: ramp channel 2 to duty 5, then release; high time must never exceed 5.
    fade_en = 1'b1;
    led_in  = 4'b0100;
    found   = 1'b0;
    for (int f = 0; f < 40 && !found; f++) begin
      run_frame();
      if (hi[2] == 5) found = 1'b1;
    end
    chk("rev_reached5", 32'(found), 32'd1);
    led_in = 4'b0000;
    prev   = 5;
    for (int f = 0; f < 12; f++) begin
      run_frame();
      chk("rev_nonincr", 32'(hi[2] <= prev), 32'd1);
      prev = hi[2];
    end
    chk("rev_end0", 32'(hi[2]), 32'd0);

    // Random pattern changes and mode toggles against the model.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 19) == 0) led_in = 4'($urandom);
      if ($urandom_range(0, 39) == 0) fade_en = ~fade_en;
      tick();
    end

    // Reset in the middle of a ramp: outputs clear without waiting for a clock.
    led_in  = 4'hF;
    fade_en = 1'b1;
    repeat (4) run_frame();
    align();
    tick();
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("async_rst_led", 32'(led_out), 32'd0);
    chk("async_rst_busy", 32'(fade_busy), 32'd0);
    model_reset();
    @(negedge sys_clk);
    @(negedge sys_clk);
    chk("rst_hold_led", 32'(led_out), 32'd0);
    sys_rst_n = 1'b1;
    run_frame();
    chk("restart_f0", 32'(hi[0]), 32'd0);
    run_frame();
    chk("restart_f1", 32'(hi[3]), 32'd0);
    run_frame();
    chk("restart_f2_ch0", 32'(hi[0]), 32'd1);
    chk("restart_f2_ch3", 32'(hi[3]), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/led_fade_pwm.md
Name: led_fade_pwm

Overview:
- Downstream stage of the 4-bit flowing-LED pattern generator: consumes its `led[3:0]` on/off pattern and drives the physical LEDs with PWM.
- Each channel's brightness ramps linearly toward its target, so the flowing light cross-fades instead of hard-switching.
- Sits between the pattern generator and the board LED pins; one clock domain, shared with the generator.

Parameters:
- PWM_PERIOD, 1000, clocks per PWM frame (20 us at 50 MHz); legal range ≥ 2.
- FADE_DIV, 10, PWM frames per one-step duty change; legal range ≥ 1. Defaults give a full 0→max ramp of 1000×10 frames = 200 ms.
- CNT_W, $clog2(PWM_PERIOD+1), width of PWM counter and duty registers (derived; do not override).

Ports:
- sys_clk  input  1  system clock, 50 MHz.
- sys_rst_n  input  1  system reset, asynchronous, active-low.
- led_in  input  4  on/off pattern from the pattern generator; bit i = 1 requests channel i fully on. Same clock domain.
- fade_en  input  1  1 = linear ramp; 0 = duty snaps to target at the next frame end.
- led_out  output  4  PWM drive to LEDs, registered, active-high.
- fade_busy  output  1  registered; 1 while any channel's duty differs from its target.

Behaviour:
- Reset (async assert, sync release by sys_clk): pwm_cnt=0, fade_cnt=0, led_in_q=0, duty[0..3]=0, led_out=4'b0000, fade_busy=0.
- Input stage: led_in_q <= led_in every clock.
  - target[i] = PWM_PERIOD if led_in_q[i] else 0.
  - Latency from a led_in change to the target change: 1 clock.
- PWM counter:
  - pwm_cnt counts 0..PWM_PERIOD-1 and wraps to 0.
  - frame_end = (pwm_cnt == PWM_PERIOD-1).
- Fade prescaler:
  - On frame_end, fade_cnt counts 0..FADE_DIV-1 and wraps.
  - step = frame_end && (fade_cnt == FADE_DIV-1).
  - With FADE_DIV=1, step = frame_end.
- Duty update (per channel, takes effect on the clock after the update event):
  - fade_en=1, on step: duty += 1 if duty < target; duty -= 1 if duty > target; else hold.
  - fade_en=0, on frame_end (regardless of fade_cnt): duty <= target.
  - Otherwise duty holds.
  - duty is therefore only modified at frame boundaries: no mid-frame glitch, no runt pulses.
  - duty stays within 0..PWM_PERIOD: no overflow or underflow, no saturating arithmetic needed.
- Output: led_out[i] <= (pwm_cnt < duty[i]), 1 clock after pwm_cnt.
  - duty=0: constant 0.
  - duty=PWM_PERIOD: constant 1.
  - duty=d: exactly d high clocks per PWM_PERIOD-clock frame.
- fade_busy <= OR over i of (duty[i] != target[i]); registered, 1 clock after the comparison.
- Boundary cases:
  - Target reverses mid-ramp: the ramp reverses from the current duty at the next step. No jump.
  - fade_en toggles mid-ramp: the new mode applies from the next frame_end/step.
  - Simultaneous led_in change and step on the same clock: step uses the old target (led_in_q not yet updated).
  - Reset mid-ramp: all duty values clear immediately and outputs go low asynchronously. After release, ramps restart from 0.
  - fade_cnt and pwm_cnt are shared by all channels, so all channels step together.

Test Plan (bench uses PWM_PERIOD=8, FADE_DIV=2 unless noted):
- Reset: hold sys_rst_n=0 with led_in=4'hF → led_out=0, fade_busy=0. Assert reset mid-ramp → led_out=0 in the same cycle (async); after release, duty restarts at 0.
- Ramp up, fade_en=1, led_in=4'b0001 from reset:
  - duty[0] increments once per 16 clocks, reaching 8 after 128 clocks.
  - Frame k (k = duty value) shows exactly k high clocks on led_out[0].
  - fade_busy=1 until duty[0]=8, then 0 one clock later. led_out[3:1] stay 0.
- Rotation cross-fade: once channel 0 is at full, change led_in to 4'b0010 → duty[0] falls 8→0 while duty[1] rises 0→8 in lockstep, one step per 16 clocks; both complete on the same step.
- Snap mode, fade_en=0:
  - led_in 4'b0000→4'b1000 mid-frame → led_out[3] constant high starting 1 clock after the next frame_end. No partial frame.
  - fade_busy=1 only until that frame_end.
- Reversal: with fade_en=1, ramp ch2 up to duty=5, then clear led_in[2] → duty goes 5→4→…→0 with no value above 5. led_out[2] high-time per frame matches duty.
- Defaults (PWM_PERIOD=1000, FADE_DIV=10): full ramp takes 10,000,000 clocks. Duty=1000 gives led_out constant 1; duty=0 gives no pulse.
